// File: rtl/sin_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sin_pkg
//  Description : Shared angle format, PI constants and sequencer state type
//                for the sine approximation datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package sin_pkg;

    localparam int W    = 27;
    localparam int FRAC = 8;

    // pi * 2^32, rounded; rescaled to FRAC bits with round-to-nearest
    localparam longint PI_Q32  = 64'sd13493037705;
    localparam int     PI      = int'((PI_Q32 + (64'sd1 <<< (31 - FRAC))) >>> (32 - FRAC));
    localparam int     TWO_PI  = 2 * PI;
    localparam int     HALF_PI = PI / 2;

    typedef logic signed [W-1:0] angle_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/angle_wrap.sv
`default_nettype none
// ============================================================================
//  Module      : angle_wrap
//  Description : (W+1)-bit add with a single +/-TWO_PI correction into [-PI, PI).
//  Revision    : 1.0 - initial release
// ============================================================================
module angle_wrap
    import sin_pkg::*;
(
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    localparam logic signed [W:0] C_PI     = (W+1)'(PI);
    localparam logic signed [W:0] C_TWO_PI = (W+1)'(TWO_PI);

    logic signed [W:0] w_sum;
    logic signed [W:0] w_fix;

    always_comb begin
        w_sum = {a[W-1], a} + {b[W-1], b};
        w_fix = w_sum;
        if (w_sum >= C_PI) begin
            w_fix = w_sum - C_TWO_PI;
        end else if (w_sum < -C_PI) begin
            w_fix = w_sum + C_TWO_PI;
        end
    end

    // After one correction the value lies back inside the W-bit range
    assign y = w_fix[W-1:0];

endmodule
`default_nettype wire

// File: rtl/sin_angle_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sin_angle_seq
//  Description : Generates base + k*step angles wrapped into [-PI, PI), plus
//                the PI/2-advanced companion for a cosine sin instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module sin_angle_seq
    import sin_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic signed [W-1:0] base_angle,
    input  logic signed [W-1:0] step,
    input  logic [CW-1:0]       count,
    input  logic                ready,
    output logic                busy,
    output logic                out_valid,
    output logic signed [W-1:0] sin_angle,
    output logic signed [W-1:0] cos_angle,
    output logic [CW-1:0]       index,
    output logic                done
);

    localparam angle_t C_PI      = W'(PI);
    localparam angle_t C_HALF_PI = W'(HALF_PI);

    state_t        r_state;
    state_t        w_state_next;
    angle_t        r_phase;
    angle_t        r_step;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_index;
    angle_t        r_sin;
    angle_t        r_cos;

    angle_t        w_phase_b;
    angle_t        w_phase_next;
    angle_t        w_cos_src;
    angle_t        w_cos;
    logic          w_in_range;
    logic          w_last;
    logic          w_advance;

    // REDUCE feeds a zero increment so the same adder performs the correction
    assign w_phase_b  = (r_state == RUN) ? r_step : '0;
    assign w_cos_src  = (r_state == RUN) ? w_phase_next : r_phase;
    assign w_in_range = (r_phase >= -C_PI) && (r_phase < C_PI);
    assign w_last     = (r_index == r_count - 1'b1);
    assign w_advance  = (r_state == RUN) && ready && !w_last;

    angle_wrap u_phase_wrap (
        .a (r_phase),
        .b (w_phase_b),
        .y (w_phase_next)
    );

    angle_wrap u_cos_wrap (
        .a (w_cos_src),
        .b (C_HALF_PI),
        .y (w_cos)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = REDUCE;
            end
            REDUCE: begin
                busy = 1'b1;
                if (w_in_range) w_state_next = (r_count == '0) ? DONE : RUN;
            end
            RUN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (ready && w_last) w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
            r_step  <= '0;
            r_count <= '0;
            r_index <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_phase <= base_angle;
                r_step  <= step;
                r_count <= count;
            end else if (r_state == REDUCE) begin
                if (!w_in_range) begin
                    r_phase <= w_phase_next;
                end else if (r_count != '0) begin
                    r_sin   <= r_phase;
                    r_cos   <= w_cos;
                    r_index <= '0;
                end
            end else if (w_advance) begin
                r_phase <= w_phase_next;
                r_sin   <= w_phase_next;
                r_cos   <= w_cos;
                r_index <= r_index + 1'b1;
            end
        end
    end

    assign sin_angle = r_sin;
    assign cos_angle = r_cos;
    assign index     = r_index;

endmodule
`default_nettype wire

// File: tb/tb_sin_angle_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sin_angle_seq
//  Description : Directed self-checking bench for the angle sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sin_angle_seq;
    import sin_pkg::*;

    localparam int CW = 16;

    logic          clk;
    logic          reset_n;
    logic          start;
    angle_t        base_angle;
    angle_t        step;
    logic [CW-1:0] count;
    logic          ready;
    logic          busy;
    logic          out_valid;
    angle_t        sin_angle;
    angle_t        cos_angle;
    logic [CW-1:0] index;
    logic          done;

    int total = 0;
    int bad   = 0;

    sin_angle_seq #(.CW(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_angle (base_angle),
        .step       (step),
        .count      (count),
        .ready      (ready),
        .busy       (busy),
        .out_valid  (out_valid),
        .sin_angle  (sin_angle),
        .cos_angle  (cos_angle),
        .index      (index),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle start pulse; returns at the negedge after the sampling edge
    task automatic do_start(input int b, input int s, input int c);
        total++;
        if (s > PI || s < -PI) begin
            bad++;
            $display("FAIL step_range: step=%0d outside required +/-%0d", s, PI);
        end
        @(negedge clk);
        start      = 1'b1;
        base_angle = W'(b);
        step       = W'(s);
        count      = CW'(c);
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        ready   = 1'b1;
        base_angle = '0;
        step    = '0;
        count   = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, out_valid, done} !== 3'b000 || sin_angle !== '0 || cos_angle !== '0 || index !== '0) begin
            bad++;
            $display("FAIL reset: busy=%b valid=%b done=%b sin=%0d cos=%0d idx=%0d required all 0",
                     busy, out_valid, done, sin_angle, cos_angle, index);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b valid=%b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        angle_t es[5] = '{0, 402, -804, -402, 0};
        angle_t ec[5] = '{402, -804, -402, 0, 402};
        do_start(0, 402, 5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || sin_angle !== es[k] || cos_angle !== ec[k] || index !== CW'(k)) begin
                bad++;
                $display("FAIL basic[%0d]: valid=%b busy=%b sin=%0d cos=%0d idx=%0d required 1 1 %0d %0d %0d",
                         k, out_valid, busy, sin_angle, cos_angle, index, es[k], ec[k], k);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: done=%b valid=%b busy=%b required 1 0 0", done, out_valid, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_reduce();
        do_start(5000, 100, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL reduce_wait[%0d]: valid=%b busy=%b required 0 1", k, out_valid, busy);
            end
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || sin_angle !== 27'sd176 || cos_angle !== 27'sd578) begin
            bad++;
            $display("FAIL reduce_5000: valid=%b sin=%0d cos=%0d required 1 176 578", out_valid, sin_angle, cos_angle);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL reduce_done: done=%b required 1", done);
        end

        do_start(-1000, 0, 1);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reduce_neg_wait: valid=%b required 0", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || sin_angle !== 27'sd608 || cos_angle !== -27'sd598) begin
            bad++;
            $display("FAIL reduce_neg: valid=%b sin=%0d cos=%0d required 1 608 -598", out_valid, sin_angle, cos_angle);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_neg_wrap();
        angle_t es[3] = '{-804, 0, -804};
        angle_t ec[3] = '{-402, 402, -402};
        do_start(-804, -804, 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || sin_angle !== es[k] || cos_angle !== ec[k] || index !== CW'(k)) begin
                bad++;
                $display("FAIL neg_wrap[%0d]: valid=%b sin=%0d cos=%0d idx=%0d required 1 %0d %0d %0d",
                         k, out_valid, sin_angle, cos_angle, index, es[k], ec[k], k);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL neg_wrap_done: done=%b required 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        angle_t es[5] = '{0, 402, -804, -402, 0};
        angle_t ec[5] = '{402, -804, -402, 0, 402};
        do_start(0, 402, 5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || sin_angle !== es[k] || cos_angle !== ec[k] || index !== CW'(k)) begin
                bad++;
                $display("FAIL bp[%0d]: valid=%b sin=%0d cos=%0d idx=%0d required 1 %0d %0d %0d",
                         k, out_valid, sin_angle, cos_angle, index, es[k], ec[k], k);
            end
            if (k == 2) begin
                ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    total++;
                    if (out_valid !== 1'b1 || done !== 1'b0 || sin_angle !== es[2] || cos_angle !== ec[2] || index !== CW'(2)) begin
                        bad++;
                        $display("FAIL bp_hold[%0d]: valid=%b done=%b sin=%0d cos=%0d idx=%0d required 1 0 -804 -402 2",
                                 h, out_valid, done, sin_angle, cos_angle, index);
                    end
                end
                ready = 1'b1;
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_done: done=%b valid=%b required 1 0", done, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        do_start(123, 10, 0);
        total++;
        if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_reduce: valid=%b done=%b busy=%b required 0 0 1", out_valid, done, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_done: done=%b valid=%b required 1 0", done, out_valid);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_idle: done=%b valid=%b busy=%b required 0 0 0", done, out_valid, busy);
        end
    endtask

    task automatic test_control();
        angle_t es[4] = '{0, 402, -804, -402};
        angle_t fs[3] = '{-804, 0, -804};
        do_start(0, 402, 5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            total++;
            if (out_valid !== 1'b1 || sin_angle !== es[k] || index !== CW'(k)) begin
                bad++;
                $display("FAIL ctrl[%0d]: valid=%b sin=%0d idx=%0d required 1 %0d %0d",
                         k, out_valid, sin_angle, index, es[k], k);
            end
            if (k == 1) begin
                start      = 1'b1;
                base_angle = 27'sd100;
                step       = 27'sd10;
                count      = 16'd2;
            end
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, out_valid, done} !== 3'b000 || sin_angle !== '0 || cos_angle !== '0 || index !== '0) begin
            bad++;
            $display("FAIL ctrl_abort: busy=%b valid=%b done=%b sin=%0d cos=%0d idx=%0d required all 0",
                     busy, out_valid, done, sin_angle, cos_angle, index);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ctrl_no_done: done=%b busy=%b required 0 0", done, busy);
        end
        do_start(-804, -804, 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || sin_angle !== fs[k] || index !== CW'(k)) begin
                bad++;
                $display("FAIL ctrl_fresh[%0d]: valid=%b sin=%0d idx=%0d required 1 %0d %0d",
                         k, out_valid, sin_angle, index, fs[k], k);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL ctrl_fresh_done: done=%b required 1", done);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reduce();
        test_neg_wrap();
        test_backpressure();
        test_zero_count();
        test_control();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sin_angle_seq.md
# sin_angle_seq

Angle sequencer that sits directly upstream of the `sin` approximation pipeline. It generates a run of evenly spaced angles, `base + k*step` for k = 0..count-1. Each angle is range-reduced into [-PI, PI), the valid input domain of the parabolic sine approximation. A second output carries the same angle advanced by PI/2, so a second `sin` instance yields the cosine, for example for building rotation matrices in `mat_mul`. The downstream pipeline's enable acts as backpressure.

## Interface
Parameters:
- `W`, 27: angle word width (two's complement, signed).
- `FRAC`, 8: fractional bits of the angle fixed-point format; must match `sin`.
- `CW`, 16: width of the sample counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `base_angle`  in  W  first angle, any signed value; captured on `start`.
- `step`  in  W  increment, |step| <= PI; captured on `start`.
- `count`  in  CW  number of samples; captured on `start`.
- `ready`  in  1  downstream accepts the current sample; drives the same cycle's `sin` enable.
- `busy`  out  1  high in REDUCE and RUN.
- `out_valid`  out  1  `sin_angle`, `cos_angle` and `index` are valid.
- `sin_angle`  out  W  current angle in [-PI, PI).
- `cos_angle`  out  W  current angle + PI/2, wrapped into [-PI, PI).
- `index`  out  CW  sample number k of the current output.
- `done`  out  1  one-cycle pulse after the last sample is accepted.

## Operation
Constants:
- PI = round(pi * 2^FRAC), which is 804 at FRAC=8.
- TWO_PI = 2*PI = 1608.
- HALF_PI = PI/2 = 402.

States:
- IDLE:
  - `start` loads the phase register with `base_angle` and latches `step` and `count`.
  - Next state is REDUCE.
- REDUCE, one correction per cycle:
  - If phase >= PI: phase -= TWO_PI.
  - Else if phase < -PI: phase += TWO_PI.
  - Else: if count == 0, go to DONE; otherwise go to RUN with index = 0.
- RUN:
  - `out_valid` is high.
  - On `ready`, if index == count-1, go to DONE.
  - Otherwise on `ready`: index += 1; phase += step, followed by a single wrap correction (add or subtract TWO_PI). One correction suffices because |step| <= PI.
  - On `!ready`, all outputs hold.
- DONE:
  - `done` is high for exactly one cycle.
  - `out_valid` is low.
  - Next state is IDLE.

Output and arithmetic rules:
- `cos_angle` is a registered output, updated together with `sin_angle`. It equals phase + HALF_PI, minus TWO_PI if the sum is >= PI.
- Internal sums are computed at W+1 bits before correction, so the adder cannot overflow.
- `start` outside IDLE is ignored; the latched parameters stay unchanged.
- `step` values outside ±PI are illegal. The block does not check them, and the bench must flag them.

## Timing
- All outputs reset to 0 and the state resets to IDLE, asynchronously.
- Asserting `reset_n` low mid-run aborts immediately; no `done` pulse is produced.
- Latency from `start` to first `out_valid` is 1 + R + 1 edges, where R is the number of REDUCE corrections. R = 0 gives `out_valid` 2 cycles after the `start` edge.
- Throughput is one sample per cycle while `ready` is high.
- `done` rises on the edge that follows acceptance of the last sample.
- `busy` is low in the `done` cycle.
- A new `start` is accepted in the cycle after `done`.

## Structure
- Package `sin_pkg` holds:
  - `W` and `FRAC`;
  - the PI, TWO_PI and HALF_PI constants, derived from FRAC;
  - the `angle_t` typedef;
  - the state enum (IDLE, REDUCE, RUN, DONE).
- `sin` is to import the same package.
- One sub-module, `angle_wrap`: a combinational (W+1)-bit add followed by a single ±TWO_PI correction. It is instanced twice, once for the phase update and once for the cosine offset.

## Test plan
Bench parameters are FRAC=8, so PI=804.
- Basic sequence: base=0, step=402, count=5, ready=1.
  - `sin_angle` = 0, 402, -804, -402, 0.
  - `cos_angle` = 402, -804, -402, 0, 402.
  - `index` = 0..4, then one `done` pulse.
- Range reduction:
  - base=5000 gives 3 corrections (3392, 1784, 176); the first `sin_angle` is 176, 5 edges after `start`.
  - base=-1000 gives a first angle of 608.
- Negative wrap: base=-804, step=-804, count=3 gives -804, 0, -804.
- Backpressure: ready held low for 3 cycles at index 2.
  - Outputs are frozen for those cycles.
  - The sequence resumes unchanged and `done` is delayed by 3 cycles.
- Zero count: count=0 gives a `done` pulse 2 cycles after `start`, with `out_valid` never high.
- Control edge cases:
  - `start` pulsed in RUN with different parameters is ignored.
  - `reset_n` low at index 3 clears all outputs to 0 immediately, with no `done`.
  - A fresh `start` then runs correctly.
